// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared sizing constants and the per-register scoreboard entry layout used
// by reg_scoreboard and its per-register reg_sb_entry instances.
//   NREG : number of architectural registers (register 0 has no entry)
//   AW   : register address width
//   TW   : width of the Tnew/Tuse cycle counters
//   TAGW : width of the producer tag
package reg_scoreboard_pkg;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int TW   = 2;
   localparam int TAGW = 3;

   typedef struct packed {
      logic            busy;
      logic [TW-1:0]   cnt;
      logic [TAGW-1:0] tag;
   } sb_entry_t;
endpackage

// File: rtl/reg_sb_entry.sv
// reg_sb_entry
// One scoreboard entry: tracks whether a register has an in-flight writer,
// how many cycles remain until its result is forwardable, and which producer
// tag currently owns the register.
// Ports:
//   Clk, Rst   : clock, asynchronous active-high reset
//   load       : accepted issue targets this register (wins over writeback)
//   load_cnt   : Tnew of the issuing instruction
//   load_tag   : tag assigned to the issuing instruction
//   wb_sel     : a writeback targets this register
//   wb_tag     : tag carried by that writeback
//   flush      : synchronous clear
//   busy, cnt  : current entry state
module reg_sb_entry
   import reg_scoreboard_pkg::*;
(
   input  logic            Clk,
   input  logic            Rst,
   input  logic            load,
   input  logic [TW-1:0]   load_cnt,
   input  logic [TAGW-1:0] load_tag,
   input  logic            wb_sel,
   input  logic [TAGW-1:0] wb_tag,
   input  logic            flush,
   output logic            busy,
   output logic [TW-1:0]   cnt
);

   sb_entry_t ent_reg;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ent_reg <= '0;
      end else if (flush) begin
         ent_reg <= '0;
      end else if (load) begin
         ent_reg.busy <= 1'b1;
         ent_reg.cnt  <= load_cnt;
         ent_reg.tag  <= load_tag;
      end else if (wb_sel && (ent_reg.tag == wb_tag)) begin
         // Only the producer that owns the register may retire it; an older
         // writeback with a stale tag leaves the newer producer in place.
         ent_reg.busy <= 1'b0;
         ent_reg.cnt  <= '0;
      end else if (ent_reg.busy && (ent_reg.cnt != '0)) begin
         // Count down to forwardable; stays busy at zero until writeback.
         ent_reg.cnt <= ent_reg.cnt - 1'b1;
      end
   end

   assign busy = ent_reg.busy;
   assign cnt  = ent_reg.cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Register-file scoreboard and hazard scheduler. Stalls decode when a source
// register's producer cannot yet forward its result, assigns producer tags to
// issuing writers and retires entries on tag-matching writebacks.
// Ports:
//   Clk, Rst                  : clock, asynchronous active-high reset
//   iss_valid                 : decode presents an instruction
//   iss_rs, iss_rt            : source registers
//   iss_tuse_rs, iss_tuse_rt  : cycles until each source is consumed
//   iss_wen, iss_dst, iss_tnew: destination write enable, register, Tnew
//   stall                     : hold decode (combinational)
//   iss_tag                   : tag for the current issue
//   wb_valid, wb_dst, wb_tag  : writeback retiring a result
//   flush                     : synchronous clear of all entries
//   busy_vec                  : per-register busy flags, bit 0 always 0
module reg_scoreboard
   import reg_scoreboard_pkg::*;
(
   input  logic            Clk,
   input  logic            Rst,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rs,
   input  logic [AW-1:0]   iss_rt,
   input  logic [TW-1:0]   iss_tuse_rs,
   input  logic [TW-1:0]   iss_tuse_rt,
   input  logic            iss_wen,
   input  logic [AW-1:0]   iss_dst,
   input  logic [TW-1:0]   iss_tnew,
   output logic            stall,
   output logic [TAGW-1:0] iss_tag,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_dst,
   input  logic [TAGW-1:0] wb_tag,
   input  logic            flush,
   output logic [NREG-1:0] busy_vec
);

   logic [TAGW-1:0] tag_ctr_reg;
   logic [NREG-1:0] busy_all;
   logic [TW-1:0]   cnt_all [NREG];
   logic            haz_rs;
   logic            haz_rt;
   logic            accept;
   logic            do_load;

   // Register 0 is hard-wired: never busy, never counts.
   assign busy_all[0] = 1'b0;
   assign cnt_all[0]  = '0;

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
         reg_sb_entry u_entry (
            .Clk      (Clk),
            .Rst      (Rst),
            .load     (do_load && (iss_dst == AW'(gi))),
            .load_cnt (iss_tnew),
            .load_tag (tag_ctr_reg),
            .wb_sel   (wb_valid && (wb_dst == AW'(gi))),
            .wb_tag   (wb_tag),
            .flush    (flush),
            .busy     (busy_all[gi]),
            .cnt      (cnt_all[gi])
         );
      end
   endgenerate

   // A source is a hazard only while its producer still needs more cycles
   // than the consumer can wait before using the value.
   assign haz_rs = (iss_rs != '0) && busy_all[iss_rs] && (cnt_all[iss_rs] > iss_tuse_rs);
   assign haz_rt = (iss_rt != '0) && busy_all[iss_rt] && (cnt_all[iss_rt] > iss_tuse_rt);

   assign stall   = iss_valid && (haz_rs || haz_rt);
   // A flush discards any same-cycle issue, so nothing is loaded or tagged.
   assign accept  = iss_valid && !stall && !flush;
   assign do_load = accept && iss_wen && (iss_dst != '0);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         tag_ctr_reg <= '0;
      end else if (do_load) begin
         tag_ctr_reg <= tag_ctr_reg + 1'b1;
      end
   end

   assign iss_tag  = tag_ctr_reg;
   assign busy_vec = busy_all;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   logic            Clk = 1'b0;
   logic            Rst;
   logic            iss_valid;
   logic [AW-1:0]   iss_rs, iss_rt, iss_dst;
   logic [TW-1:0]   iss_tuse_rs, iss_tuse_rt, iss_tnew;
   logic            iss_wen;
   logic            stall;
   logic [TAGW-1:0] iss_tag;
   logic            wb_valid;
   logic [AW-1:0]   wb_dst;
   logic [TAGW-1:0] wb_tag;
   logic            flush;
   logic [NREG-1:0] busy_vec;

   int checks = 0;
   int errors = 0;

   reg_scoreboard dut (
      .Clk(Clk), .Rst(Rst),
      .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
      .iss_tuse_rs(iss_tuse_rs), .iss_tuse_rt(iss_tuse_rt),
      .iss_wen(iss_wen), .iss_dst(iss_dst), .iss_tnew(iss_tnew),
      .stall(stall), .iss_tag(iss_tag),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_tag(wb_tag),
      .flush(flush), .busy_vec(busy_vec)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: absolute ready times ----------------
   bit m_busy  [NREG];
   int m_ready [NREG];   // cycle from which the result is forwardable
   int m_tag   [NREG];
   int m_tagctr;
   int cyc;

   function automatic int remaining(int r);
      return (m_ready[r] > cyc) ? (m_ready[r] - cyc) : 0;
   endfunction

   function automatic bit m_haz(int s, int tuse);
      return (s != 0) && m_busy[s] && (remaining(s) > tuse);
   endfunction

   function automatic bit m_stall();
      return iss_valid && (m_haz(int'(iss_rs), int'(iss_tuse_rs)) ||
                           m_haz(int'(iss_rt), int'(iss_tuse_rt)));
   endfunction

   function automatic logic [31:0] m_busyvec();
      logic [31:0] v = '0;
      for (int r = 1; r < NREG; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < NREG; r++) begin
         m_busy[r] = 0; m_ready[r] = 0; m_tag[r] = 0;
      end
      m_tagctr = 0;
      cyc = 0;
   endtask

   // Applies the rules for one rising edge using the inputs of this cycle.
   task automatic m_clock();
      bit acc;
      acc = iss_valid && !m_stall() && !flush;
      if (flush) begin
         for (int r = 0; r < NREG; r++) m_busy[r] = 0;
      end else begin
         if (wb_valid && wb_dst != 0 && m_tag[wb_dst] == int'(wb_tag))
            m_busy[wb_dst] = 0;
         if (acc && iss_wen && iss_dst != 0) begin
            m_busy[iss_dst]  = 1;
            m_ready[iss_dst] = cyc + 1 + int'(iss_tnew);
            m_tag[iss_dst]   = m_tagctr;
            m_tagctr         = (m_tagctr + 1) % (1 << TAGW);
         end
      end
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; compares against the
   // model (and optional constants), clocks, and returns at the next negedge.
   task automatic cycle(input bit use_exp, input logic e_stall, input logic [2:0] e_tag,
                        input logic [31:0] e_busy, input string nm);
      #1;
      chk({nm, " stall/model"},    32'(stall),    32'(m_stall()));
      chk({nm, " iss_tag/model"},  32'(iss_tag),  32'(m_tagctr));
      chk({nm, " busy_vec/model"}, 32'(busy_vec), m_busyvec());
      if (use_exp) begin
         chk({nm, " stall"},    32'(stall),    32'(e_stall));
         chk({nm, " iss_tag"},  32'(iss_tag),  32'(e_tag));
         chk({nm, " busy_vec"}, 32'(busy_vec), e_busy);
      end
      $display("cyc %0d %s: v=%0b rs=%0d rt=%0d wen=%0b dst=%0d wb=%0b/%0d/%0d fl=%0b -> stall=%0b tag=%0d busy=%h",
               cyc, nm, iss_valid, iss_rs, iss_rt, iss_wen, iss_dst, wb_valid, wb_dst, wb_tag,
               flush, stall, iss_tag, busy_vec);
      @(posedge Clk);
      m_clock();
      @(negedge Clk);
   endtask

   task automatic idle_inputs();
      iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_tuse_rs = 0; iss_tuse_rt = 0;
      iss_wen = 0; iss_dst = 0; iss_tnew = 0;
      wb_valid = 0; wb_dst = 0; wb_tag = 0; flush = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic iv; logic [4:0] rs; logic [1:0] trs; logic [4:0] rt; logic [1:0] trt;
      logic wen; logic [4:0] dst; logic [1:0] tnew;
      logic wbv; logic [4:0] wbd; logic [2:0] wbt; logic fl;
      logic e_stall; logic [2:0] e_tag; logic [31:0] e_busy;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input int iv, rs, trs, rt, trt, wen, dst, tnew,
                      wbv, wbd, wbt, fl, es, et, input logic [31:0] eb);
      vec_t v;
      v.iv = iv[0]; v.rs = rs[4:0]; v.trs = trs[1:0]; v.rt = rt[4:0]; v.trt = trt[1:0];
      v.wen = wen[0]; v.dst = dst[4:0]; v.tnew = tnew[1:0];
      v.wbv = wbv[0]; v.wbd = wbd[4:0]; v.wbt = wbt[2:0]; v.fl = fl[0];
      v.e_stall = es[0]; v.e_tag = et[2:0]; v.e_busy = eb;
      vecs.push_back(v);
   endtask

   initial begin
      //  iv rs trs rt trt wen dst tn  wbv wbd wbt fl   stall tag busy
      add(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 0, 32'h0);        // idle after reset
      add(1, 0, 0, 0, 0, 1,  8, 2,  0,  0, 0, 0,   0, 0, 32'h0);        // load-use producer
      add(1, 8, 0, 0, 0, 1, 10, 1,  0,  0, 0, 0,   1, 1, 32'h100);
      add(1, 8, 0, 0, 0, 1, 10, 1,  0,  0, 0, 0,   1, 1, 32'h100);
      add(1, 8, 0, 0, 0, 1, 10, 1,  0,  0, 0, 0,   0, 1, 32'h100);      // accepted on 3rd
      add(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 2, 32'h500);
      add(1, 0, 0, 0, 0, 1,  0, 3,  0,  0, 0, 0,   0, 2, 32'h500);      // dst=0 write
      add(1, 0, 0, 0, 0, 0,  0, 0,  1,  8, 0, 0,   0, 2, 32'h500);      // rs=0, wb 8
      add(0, 0, 0, 0, 0, 0,  0, 0,  1, 10, 1, 0,   0, 2, 32'h400);
      add(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 2, 32'h0);
      add(1, 0, 0, 0, 0, 1,  5, 1,  0,  0, 0, 0,   0, 2, 32'h0);        // r5 tag 2
      add(1, 0, 0, 0, 0, 1,  5, 3,  0,  0, 0, 0,   0, 3, 32'h20);       // r5 tag 3
      add(0, 0, 0, 0, 0, 0,  0, 0,  1,  5, 2, 0,   0, 4, 32'h20);       // stale wb
      add(0, 0, 0, 0, 0, 0,  0, 0,  1,  5, 3, 0,   0, 4, 32'h20);       // owner wb
      add(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 4, 32'h0);
      add(1, 0, 0, 0, 0, 1,  9, 1,  0,  0, 0, 0,   0, 4, 32'h0);        // r9 tag 4
      add(1, 0, 0, 0, 0, 1,  9, 3,  1,  9, 4, 0,   0, 5, 32'h200);      // load vs wb collision
      add(1, 9, 2, 0, 0, 0,  0, 0,  0,  0, 0, 0,   1, 6, 32'h200);      // cnt=3 > tuse 2
      add(1, 9, 2, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 6, 32'h200);
      add(0, 0, 0, 0, 0, 0,  0, 0,  1,  9, 4, 0,   0, 6, 32'h200);      // old tag ignored
      add(1, 0, 0, 0, 0, 1,  3, 3,  0,  0, 0, 0,   0, 6, 32'h200);
      add(1, 0, 0, 0, 0, 1,  7, 3,  0,  0, 0, 0,   0, 7, 32'h208);
      add(1, 0, 0, 0, 0, 1, 12, 2,  0,  0, 0, 0,   0, 0, 32'h288);      // tag wrapped
      add(1, 0, 0, 0, 0, 1, 14, 1,  0,  0, 0, 1,   0, 1, 32'h1288);     // flush + issue
      add(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 1, 32'h0);
      add(1, 3, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 1, 32'h0);
      add(1, 0, 0, 0, 0, 1, 20, 3,  0,  0, 0, 0,   0, 1, 32'h0);
      add(1, 0, 0,20, 1, 1, 21, 2,  0,  0, 0, 0,   1, 2, 32'h100000);   // rt hazard
      add(1, 0, 0,20, 1, 1, 21, 2,  0,  0, 0, 0,   1, 2, 32'h100000);
      add(1, 0, 0,20, 1, 1, 21, 2,  0,  0, 0, 0,   0, 2, 32'h100000);
      add(0,20, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 3, 32'h300000);   // no valid, no stall
      add(0, 0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0,   0, 3, 32'h300000);   // cnt 0 stays busy

      idle_inputs();
      m_reset();
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      #1;
      chk("reset busy_vec", 32'(busy_vec), 32'h0);
      chk("reset iss_tag",  32'(iss_tag),  32'h0);
      chk("reset stall",    32'(stall),    32'h0);
      @(negedge Clk);
      Rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         iss_valid = vecs[i].iv; iss_rs = vecs[i].rs; iss_tuse_rs = vecs[i].trs;
         iss_rt = vecs[i].rt; iss_tuse_rt = vecs[i].trt;
         iss_wen = vecs[i].wen; iss_dst = vecs[i].dst; iss_tnew = vecs[i].tnew;
         wb_valid = vecs[i].wbv; wb_dst = vecs[i].wbd; wb_tag = vecs[i].wbt;
         flush = vecs[i].fl;
         cycle(1, vecs[i].e_stall, vecs[i].e_tag, vecs[i].e_busy, $sformatf("vec%0d", i));
      end

      // Asynchronous reset in the middle of a stalled cycle.
      idle_inputs();
      iss_valid = 1; iss_wen = 1; iss_dst = 4; iss_tnew = 3;
      cycle(0, 0, 0, 0, "pre-reset issue");
      idle_inputs();
      iss_valid = 1; iss_rs = 4; iss_tuse_rs = 0;
      #1;
      chk("pre-reset stall", 32'(stall), 32'h1);
      #2 Rst = 1'b1;
      #1;
      chk("async reset stall",    32'(stall),    32'h0);
      chk("async reset iss_tag",  32'(iss_tag),  32'h0);
      chk("async reset busy_vec", 32'(busy_vec), 32'h0);
      $display("async reset: stall=%0b tag=%0d busy=%h", stall, iss_tag, busy_vec);
      m_reset();
      @(negedge Clk);
      idle_inputs();
      Rst = 1'b0;

      // Randomized traffic over a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         iss_valid   = ($urandom_range(3) != 0);
         iss_rs      = AW'($urandom_range(7));
         iss_rt      = AW'($urandom_range(7));
         iss_tuse_rs = TW'($urandom_range(3));
         iss_tuse_rt = TW'($urandom_range(3));
         iss_wen     = ($urandom_range(3) != 0);
         iss_dst     = AW'($urandom_range(7));
         iss_tnew    = TW'($urandom_range(3));
         wb_valid    = $urandom_range(1) == 1;
         wb_dst      = AW'($urandom_range(7));
         wb_tag      = ($urandom_range(2) != 0) ? TAGW'(m_tag[wb_dst]) : TAGW'($urandom_range(7));
         flush       = ($urandom_range(39) == 0);
         cycle(0, 0, 0, 0, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
